image_timing_controller: RTL and testbench

IMAGE_TIMING_CONTROLLER -- requirements
Module: image_timing_controller

---
 rtl/image_timing_controller_if.sv | 27 ++
 rtl/image_timing_controller.sv | 136 +++++++++++++
 tb/tb_image_timing_controller.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/image_timing_controller_if.sv
// Video timing inputs and locked-geometry outputs of the image timing controller.
// The controller side uses the slave modport; the video source/host side uses master.
interface image_timing_controller_if #(
   parameter int W_BITS    = 12,
   parameter int MODE_BITS = 3
);
   logic                 iHSync;
   logic                 iVSync;
   logic                 iDataValid;
   logic [MODE_BITS-1:0] iMode;
   logic [MODE_BITS-1:0] oMode;
   logic                 oLocked;
   logic [W_BITS-1:0]    oWidth;
   logic [W_BITS-1:0]    oHeight;
   logic                 oFrameStart;
   logic [7:0]           oErrCnt;

   modport slave (
      input  iHSync, iVSync, iDataValid, iMode,
      output oMode, oLocked, oWidth, oHeight, oFrameStart, oErrCnt
   );

   modport master (
      output iHSync, iVSync, iDataValid, iMode,
      input  oMode, oLocked, oWidth, oHeight, oFrameStart, oErrCnt
   );
endinterface

// File: rtl/image_timing_controller.sv
// Measures frame geometry from vsync/data-valid, locks after two matching frames,
// and gates the processing mode so it only changes at a frame boundary while locked.
module image_timing_controller #(
   parameter int W_BITS    = 12,
   parameter int MODE_BITS = 3
) (
   input  logic                      iClk,
   input  logic                      iRst,
   image_timing_controller_if.slave  bus
);
   localparam logic [W_BITS-1:0] CNT_MAX   = '1;
   localparam logic [W_BITS-1:0] CNT_MAXM1 = CNT_MAX - 1'b1;

   typedef enum logic [1:0] {IDLE, ACQUIRE, CONFIRM, LOCKED} state_t;

   state_t               r_state, w_state_nxt;
   logic                 r_vs_d, r_dv_d, r_fs;
   logic [W_BITS-1:0]    r_pix, r_lines, r_first;
   logic                 r_mism, r_sat;
   logic [W_BITS-1:0]    r_cand_w, r_cand_h, r_width, r_height;
   logic [MODE_BITS-1:0] r_mode;
   logic [7:0]           r_err;

   logic                 w_vs_rise, w_line_end;
   logic [W_BITS-1:0]    w_lines_f, w_width_f;
   logic                 w_mism_f, w_sat_f, w_valid;
   logic                 w_match_cand, w_match_lock;
   logic                 w_load_cand, w_load_lock, w_err_inc;
   logic                 w_unused_hsync;

   assign w_unused_hsync = bus.iHSync;

   assign w_vs_rise  = bus.iVSync & ~r_vs_d;
   assign w_line_end = ~bus.iDataValid & r_dv_d;

   // Closing-frame view that folds in a line ending in the vsync-rise cycle itself
   assign w_lines_f    = (w_line_end && r_lines != CNT_MAX) ? r_lines + 1'b1 : r_lines;
   assign w_width_f    = (r_lines == '0) ? r_pix : r_first;
   assign w_mism_f     = r_mism | (w_line_end && r_lines != '0 && r_pix != r_first);
   assign w_sat_f      = r_sat | (w_lines_f == CNT_MAX);
   assign w_valid      = (w_lines_f != '0) & ~w_mism_f & ~w_sat_f & ~bus.iDataValid;
   assign w_match_cand = (w_width_f == r_cand_w) && (w_lines_f == r_cand_h);
   assign w_match_lock = (w_width_f == r_width)  && (w_lines_f == r_height);

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load_cand = 1'b0;
      w_load_lock = 1'b0;
      w_err_inc   = 1'b0;
      if (w_vs_rise) begin
         case (r_state)
            IDLE:    w_state_nxt = ACQUIRE;
            ACQUIRE: if (w_valid) begin
                        w_load_cand = 1'b1;
                        w_state_nxt = CONFIRM;
                     end
            CONFIRM: if (!w_valid) begin
                        w_state_nxt = ACQUIRE;
                     end else if (w_match_cand) begin
                        w_load_lock = 1'b1;
                        w_state_nxt = LOCKED;
                     end else begin
                        w_load_cand = 1'b1;
                     end
            LOCKED:  if (!(w_valid && w_match_lock)) begin
                        w_err_inc   = 1'b1;
                        w_load_cand = w_valid;
                        w_state_nxt = w_valid ? CONFIRM : ACQUIRE;
                     end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         r_vs_d   <= 1'b0;
         r_dv_d   <= 1'b0;
         r_fs     <= 1'b0;
         r_pix    <= '0;
         r_lines  <= '0;
         r_first  <= '0;
         r_mism   <= 1'b0;
         r_sat    <= 1'b0;
         r_cand_w <= '0;
         r_cand_h <= '0;
         r_width  <= '0;
         r_height <= '0;
         r_mode   <= '0;
         r_err    <= '0;
      end else begin
         r_vs_d <= bus.iVSync;
         r_dv_d <= bus.iDataValid;
         r_fs   <= w_vs_rise;
         if (w_vs_rise) begin
            // Frame boundary: counters restart; pixels in this cycle belong to no line
            r_pix   <= '0;
            r_lines <= '0;
            r_first <= '0;
            r_mism  <= 1'b0;
            r_sat   <= 1'b0;
            if (w_load_cand) begin
               r_cand_w <= w_width_f;
               r_cand_h <= w_lines_f;
            end
            if (w_load_lock) begin
               r_width  <= w_width_f;
               r_height <= w_lines_f;
            end
            if (w_err_inc && r_err != 8'hFF) r_err <= r_err + 8'd1;
            r_mode <= (w_state_nxt == LOCKED) ? bus.iMode : '0;
         end else if (bus.iDataValid) begin
            if (r_pix != CNT_MAX) r_pix <= r_pix + 1'b1;
            if (r_pix == CNT_MAXM1) r_sat <= 1'b1;
         end else if (r_dv_d) begin
            r_pix <= '0;
            if (r_lines != CNT_MAX)  r_lines <= r_lines + 1'b1;
            if (r_lines == CNT_MAXM1) r_sat <= 1'b1;
            if (r_lines == '0)        r_first <= r_pix;
            else if (r_pix != r_first) r_mism <= 1'b1;
         end
      end
   end

   assign bus.oMode       = r_mode;
   assign bus.oLocked     = (r_state == LOCKED);
   assign bus.oWidth      = r_width;
   assign bus.oHeight     = r_height;
   assign bus.oFrameStart = r_fs;
   assign bus.oErrCnt     = r_err;
endmodule

// File: tb/tb_image_timing_controller.sv
// Randomized frame stimulus for two controller instances (12-bit and 4-bit counters),
// checked by a frame-level reference model through per-instance expectation queues.
module tb_image_timing_controller;
   localparam int S_IDLE = 0, S_ACQ = 1, S_CONF = 2, S_LOCK = 3;

   typedef struct {
      int lk;
      int w;
      int h;
      int mo;
      int err;
   } exp_t;

   logic       clk, rst, vs, dv, hs;
   logic [2:0] md;

   image_timing_controller_if #(.W_BITS(12), .MODE_BITS(3)) if12();
   image_timing_controller_if #(.W_BITS(4),  .MODE_BITS(3)) if4();

   assign if12.iHSync = hs;  assign if12.iVSync = vs;
   assign if12.iDataValid = dv;  assign if12.iMode = md;
   assign if4.iHSync = hs;   assign if4.iVSync = vs;
   assign if4.iDataValid = dv;   assign if4.iMode = md;

   image_timing_controller #(.W_BITS(12), .MODE_BITS(3)) u12 (.iClk(clk), .iRst(rst), .bus(if12.slave));
   image_timing_controller #(.W_BITS(4),  .MODE_BITS(3)) u4  (.iClk(clk), .iRst(rst), .bus(if4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   total = 0, passed = 0;
   exp_t q0[$], q1[$];

   // Reference model: run lengths of the current frame, per-instance lock progress
   int   runs[$];
   int   cnt;
   bit   pv, pd, carry_hi;
   int   mmax[2] = '{4095, 15};
   int   ph[2], cw[2], ch[2], ow[2], oh[2], omd[2], oerr[2];

   task automatic model_reset();
      runs.delete();
      cnt = 0; pv = 0; pd = 0; carry_hi = 0;
      for (int m = 0; m < 2; m++) begin
         ph[m] = S_IDLE; cw[m] = 0; ch[m] = 0; ow[m] = 0; oh[m] = 0; omd[m] = 0; oerr[m] = 0;
      end
   endtask

   function automatic bit frame_ok(int mx, bit dv_at_vs);
      if (dv_at_vs || runs.size() == 0 || runs.size() >= mx) return 1'b0;
      foreach (runs[i]) if (runs[i] != runs[0] || runs[i] >= mx) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_frame(int m, bit ok, int w, int h);
      exp_t e;
      case (ph[m])
         S_IDLE: ph[m] = S_ACQ;
         S_ACQ:  if (ok) begin cw[m] = w; ch[m] = h; ph[m] = S_CONF; end
         S_CONF: if (!ok) ph[m] = S_ACQ;
                 else if (w == cw[m] && h == ch[m]) begin ph[m] = S_LOCK; ow[m] = w; oh[m] = h; end
                 else begin cw[m] = w; ch[m] = h; end
         default: if (!(ok && w == ow[m] && h == oh[m])) begin
                     if (oerr[m] < 255) oerr[m]++;
                     if (ok) begin cw[m] = w; ch[m] = h; ph[m] = S_CONF; end
                     else ph[m] = S_ACQ;
                  end
      endcase
      omd[m] = (ph[m] == S_LOCK) ? int'(md) : 0;
      e.lk = (ph[m] == S_LOCK); e.w = ow[m]; e.h = oh[m]; e.mo = omd[m]; e.err = oerr[m];
      if (m == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic model_sample(bit v, bit d);
      if (v && !pv) begin
         if (!d && pd) runs.push_back(cnt);
         for (int m = 0; m < 2; m++)
            model_frame(m, frame_ok(mmax[m], d), (runs.size() > 0) ? runs[0] : 0, runs.size());
         runs.delete();
         cnt = 0;
      end else if (d) begin
         cnt++;
      end else if (pd) begin
         runs.push_back(cnt);
         cnt = 0;
      end
      pv = v; pd = d;
   endtask

   task automatic cyc(bit v, bit d);
      vs = v; dv = d; hs = 1'($urandom);
      model_sample(v, d);
      @(posedge clk); #1;
   endtask

   // tail: 0 normal gap, 1 last line ends in the next vsync cycle, 2 data valid held across vsync
   task automatic frame(int nl, int len, int oddi, int oddl, int tail, int mode);
      md = 3'(mode);
      cyc(1, carry_hi);
      cyc(1, 0);
      cyc(0, 0);
      for (int l = 0; l < nl; l++) begin
         int n;
         n = (l == oddi) ? oddl : len;
         for (int k = 0; k < n; k++) cyc(0, 1);
         if (!(l == nl - 1 && tail != 0)) repeat (1 + $urandom_range(0, 2)) cyc(0, 0);
      end
      carry_hi = (tail == 2);
      if (tail == 2) cyc(0, 1);
   endtask

   task automatic chk(int m, int lk, int w, int h, int mo, int er);
      exp_t e;
      total++;
      if ((m == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
         $display("FAIL fs_unexpected dut%0d: frame start pulse with no frame boundary expected", m);
         return;
      end
      e = (m == 0) ? q0.pop_front() : q1.pop_front();
      if (e.lk == lk && e.w == w && e.h == h && e.mo == mo && e.err == er) passed++;
      else $display("FAIL frame dut%0d t=%0t: got lk=%0d w=%0d h=%0d mode=%0d err=%0d, want lk=%0d w=%0d h=%0d mode=%0d err=%0d",
                    m, $time, lk, w, h, mo, er, e.lk, e.w, e.h, e.mo, e.err);
   endtask

   task automatic check_zero(string name);
      int a;
      a = int'(if12.oLocked) + int'(if12.oWidth) + int'(if12.oHeight) + int'(if12.oMode)
        + int'(if12.oErrCnt) + int'(if12.oFrameStart) + int'(if4.oLocked) + int'(if4.oWidth)
        + int'(if4.oHeight) + int'(if4.oMode) + int'(if4.oErrCnt) + int'(if4.oFrameStart);
      total++;
      if (a == 0) passed++;
      else $display("FAIL %s: output sum %0d, required 0 (lk=%0d w=%0d h=%0d mode=%0d err=%0d)",
                    name, a, if12.oLocked, if12.oWidth, if12.oHeight, if12.oMode, if12.oErrCnt);
   endtask

   // Monitor: each frame-start pulse presents one frame's verdict
   always @(negedge clk) begin
      if (rst) begin
         if (if12.oFrameStart === 1'b1)
            chk(0, int'(if12.oLocked), int'(if12.oWidth), int'(if12.oHeight), int'(if12.oMode), int'(if12.oErrCnt));
         if (if4.oFrameStart === 1'b1)
            chk(1, int'(if4.oLocked), int'(if4.oWidth), int'(if4.oHeight), int'(if4.oMode), int'(if4.oErrCnt));
      end
   end

   int gl[3] = '{2, 3, 1};
   int gw[3] = '{5, 9, 13};

   initial begin
      int g;
      rst = 1'b0; vs = 1'b0; dv = 1'b0; hs = 1'b0; md = 3'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_zero("reset_state");
      rst = 1'b1;
      @(posedge clk); #1;

      repeat (4) frame(4, 640, -1, 0, 0, 5);     // lock on 640x4, mode 5
      frame(4, 640, 1, 639, 0, 5);               // short line 2 breaks lock
      repeat (3) frame(4, 640, -1, 0, 0, 5);     // relock
      frame(4, 640, -1, 0, 2, 6);                // data valid across vsync
      repeat (4) frame(3, 20, -1, 0, 0, 2);      // 20-pixel lines saturate the 4-bit counter
      repeat (4) frame(2, 7, -1, 0, 1, 3);       // line end coincides with vsync

      // Asynchronous reset mid-frame while locked
      md = 3'd4;
      cyc(1, 0); cyc(0, 0);
      repeat (5) cyc(0, 1);
      cyc(0, 0); cyc(0, 0);
      #2 rst = 1'b0;
      #1 check_zero("async_reset");
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      repeat (4) frame(2, 7, -1, 0, 0, 4);

      g = 0;
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 3) == 0) g = $urandom_range(0, 2);
         if ($urandom_range(0, 5) == 0)
            frame(gl[g] + 1, gw[g], $urandom_range(0, gl[g]), gw[g] + 1, $urandom_range(0, 2), $urandom_range(0, 7));
         else
            frame(gl[g], gw[g], -1, 0, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0, $urandom_range(0, 7));
      end

      // Repeated lock / break cycles drive the error counter into saturation
      repeat (3) frame(1, 3, -1, 0, 0, 1);
      for (int i = 0; i < 265; i++) begin
         frame(1, 2, -1, 0, 0, 1);
         frame(1, 3, -1, 0, 0, 1);
         frame(1, 3, -1, 0, 0, 1);
      end
      md = 3'd1;
      cyc(1, 0);
      repeat (4) cyc(0, 0);

      total++;
      if (if12.oErrCnt == 8'd255 && if4.oErrCnt == 8'd255) passed++;
      else $display("FAIL err_saturate: got %0d/%0d, required 255/255", if12.oErrCnt, if4.oErrCnt);
      total++;
      if (q0.size() == 0 && q1.size() == 0) passed++;
      else $display("FAIL missing_frame_start: %0d/%0d expected pulses never seen, required 0", q0.size(), q1.size());

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
